sha256_iter_core: RTL



---
 rtl/sha256_pkg.sv | 54 +++++
 rtl/sha256_round.sv | 20 ++
 rtl/sha256_iter_core.sv | 114 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, types and round helper functions shared by the compression core.
// Pure definitions: no latency, no flow control.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:7] state_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t [0:63] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(word_t e, word_t f, word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(word_t a, word_t b, word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t bsig0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 round as pure combinational logic; chained RPC times by the core.
// Zero latency, no flow control.
module sha256_round
  import sha256_pkg::*;
(
  input  state_t cur,
  input  word_t  kt,
  input  word_t  wt,
  output state_t nxt
);

  word_t t1, t2;

  always_comb begin
    t1  = cur[7] + bsig1(cur[4]) + ch(cur[4], cur[5], cur[6]) + kt + wt;
    t2  = bsig0(cur[0]) + maj(cur[0], cur[1], cur[2]);
    nxt = {t1 + t2, cur[0], cur[1], cur[2], cur[3] + t1, cur[4], cur[5], cur[6]};
  end

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 block compressor, RPC rounds per clock; accept-to-out_valid is 64/RPC+1 edges.
// Output holds until out_ready; a new block is only taken in IDLE or on the same edge DONE drains.
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int RPC = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_redo,
  input  logic [511:0] in_message,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_hash,
  output logic         busy
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("sha256_iter_core: RPC must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] LAST_RND = 6'(64 - RPC);

  fsm_t              state, state_nxt;
  state_t            work, base, chain, sel, digest;
  word_t [0:15]      w;
  word_t [0:15+RPC]  ext;
  logic  [5:0]       rnd;
  logic              accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: if (rnd == LAST_RND) state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? ROUND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // first beats redo; redo keeps the base register as-is
  always_comb begin
    if (in_first)     sel = IV;
    else if (in_redo) sel = base;
    else              sel = chain;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) digest[i] = base[i] + work[i];
  end

  // Window holds W[rnd..rnd+15]; extend it by RPC words for this cycle's rounds
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int i = 0; i < RPC; i++)
      ext[16+i] = ssig1(ext[14+i]) + ext[9+i] + ssig0(ext[1+i]) + ext[i];
  end

  for (genvar gi = 0; gi < RPC; gi++) begin : g_rnd
    state_t     src, dst;
    logic [5:0] kidx;
    if (gi == 0) begin : g_head
      assign src = work;
    end else begin : g_link
      assign src = g_rnd[gi-1].dst;
    end
    assign kidx = rnd + 6'(gi);
    sha256_round u_round (.cur(src), .kt(K[kidx]), .wt(ext[gi]), .nxt(dst));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work     <= IV;
      base     <= IV;
      chain    <= IV;
      w        <= '0;
      rnd      <= '0;
      out_hash <= '0;
    end else if (accept) begin
      base <= sel;
      work <= sel;
      w    <= in_message;
      rnd  <= '0;
    end else if (state == ROUND) begin
      work <= g_rnd[RPC-1].dst;
      w    <= ext[RPC +: 16];
      rnd  <= rnd + 6'(RPC);
    end else if (state == FINAL) begin
      out_hash <= digest;
      chain    <= digest;
    end
  end

endmodule
